oai_cell_exerciser: RTL and testbench

- Initiator side of the complex-gate cell interface. It drives the four inputs a, b, c and d of a 4-input complex CMOS gate (OAI22 or AOI22) and samples the gate output f.
- Sweeps all 16 input vectors exhaustively and compares each sample against a golden model.
- Reports the pass/fail result, the mismatch count and the first failing vector.
- Used as the on-chip/bench self-check wrapper around switch-level gate cells.

---
 rtl/oai_cell_exerciser_pkg.sv | 18 +
 rtl/oai_cell_exerciser_gate_ref_model.sv | 19 +
 rtl/oai_cell_exerciser.sv | 140 ++++++++++++++
 tb/tb_oai_cell_exerciser.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/oai_cell_exerciser_pkg.sv
// Shared definitions for the complex-gate cell exercisers: FSM states,
// mode encodings and the vector space swept across the gate inputs.
package oai_cell_exerciser_pkg;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;

    localparam logic MODE_OAI22 = 1'b0;
    localparam logic MODE_AOI22 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/oai_cell_exerciser_gate_ref_model.sv
// Golden model of a 4-input complex gate, selectable between OAI22 and AOI22.
// Vector bit order is {a,b,c,d}.
module gate_ref_model
    import oai_cell_exerciser_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    input  logic             mode,
    output logic             exp_f
);

    always_comb begin
        if (mode == MODE_AOI22) begin
            exp_f = ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
        end else begin
            exp_f = ~((vec[3] | vec[2]) & (vec[1] | vec[0]));
        end
    end

endmodule

// File: rtl/oai_cell_exerciser.sv
// Sweeps all 16 input vectors through an external OAI22/AOI22 cell, compares
// each settled output against the golden model and reports the result.
module oai_cell_exerciser
    import oai_cell_exerciser_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    output logic             dut_d,
    input  logic             dut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_count,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid
);

    localparam logic [3:0]       SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC      = VEC_W'(NUM_VEC - 1);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [4:0]         err_q, err_d;
    logic [VEC_W-1:0]   ffv_q, ffv_d;
    logic               ffvalid_q, ffvalid_d;
    logic               pass_q, pass_d;
    logic               exp_f;
    logic               mismatch;

    gate_ref_model u_ref (
        .vec   (vec_q),
        .mode  (mode_q),
        .exp_f (exp_f)
    );

    // An unknown dut_f makes the equality unknown, which falls through to the
    // mismatch default rather than being counted as a match.
    always_comb begin
        mismatch = 1'b1;
        if (dut_f == exp_f) begin
            mismatch = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        pass_d    = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    err_d     = 5'd0;
                    pass_d    = 1'b0;
                    ffvalid_d = 1'b0;
                    ffv_d     = '0;
                    vec_d     = '0;
                    cnt_d     = SETTLE_RELOAD;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    if (!ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = SETTLE_RELOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                pass_d  = (err_q == 5'd0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            cnt_q     <= 4'd0;
            mode_q    <= MODE_OAI22;
            err_q     <= 5'd0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
            pass_q    <= pass_d;
        end
    end

    assign dut_a            = vec_q[3];
    assign dut_b            = vec_q[2];
    assign dut_c            = vec_q[1];
    assign dut_d            = vec_q[0];
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_oai_cell_exerciser.sv
// Directed bench for oai_cell_exerciser: two instances (default settle and
// SETTLE_CYCLES=1) each driving a behavioural OAI22 cell with optional stuck-at-0.
module tb_oai_cell_exerciser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic       mode = 1'b0;
    logic       fault = 1'b0;
    logic       sel = 1'b0;

    logic       a0, b0, c0, d0, f0, busy0, done0, pass0, ffvalid0;
    logic [4:0] err0;
    logic [3:0] ffv0;
    logic       a1, b1, c1, d1, f1, busy1, done1, pass1, ffvalid1;
    logic [4:0] err1;
    logic [3:0] ffv1;

    logic       busy_m, done_m, pass_m, ffvalid_m;
    logic [4:0] err_m;
    logic [3:0] ffv_m, vec_m;

    int tests  = 0;
    int failed = 0;
    int busy_cycles;
    int done_pulses;

    always #5 clk = ~clk;

    // Behavioural OAI22 cells under test, optionally stuck at 0.
    assign f0 = fault ? 1'b0 : ~((a0 | b0) & (c0 | d0));
    assign f1 = fault ? 1'b0 : ~((a1 | b1) & (c1 | d1));

    oai_cell_exerciser u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode),
        .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_d(d0), .dut_f(f0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffvalid0)
    );

    oai_cell_exerciser #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode),
        .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_d(d1), .dut_f(f1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
    );

    assign busy_m    = sel ? busy1    : busy0;
    assign done_m    = sel ? done1    : done0;
    assign pass_m    = sel ? pass1    : pass0;
    assign ffvalid_m = sel ? ffvalid1 : ffvalid0;
    assign err_m     = sel ? err1     : err0;
    assign ffv_m     = sel ? ffv1     : ffv0;
    assign vec_m     = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Pulses start on the selected instance and follows the sweep to the end,
    // counting busy cycles and done pulses. Optionally re-pulses start and
    // flips mode mid-sweep. A sweep that never ends reports busy_cycles = -1.
    task automatic applyStimulus(input logic use_inst1, input logic m, input logic disturb,
                                 output int n_busy, output int n_done);
        bit finished = 1'b0;
        sel = use_inst1;
        @(negedge clk);
        mode = m;
        if (use_inst1) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        n_busy = 0;
        n_done = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy_m) begin
                finished = 1'b1;
                break;
            end
            n_busy++;
            if (done_m) n_done++;
            if (disturb && i == 10) begin
                if (use_inst1) start1 = 1'b1; else start0 = 1'b1;
                mode = ~m;
            end
            if (disturb && i == 11) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            @(negedge clk);
        end
        if (!finished) n_busy = -1;
        mode = m;
    endtask

    initial begin
        $display("[TB] starting oai_cell_exerciser directed test");
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", int'(busy0), 0);
        checkOutput("reset_vec", int'({a0, b0, c0, d0}), 0);
        checkOutput("reset_err", int'(err0), 0);
        rst = 1'b0;
        @(negedge clk);

        // Correct OAI22 cell checked as OAI22.
        applyStimulus(1'b0, 1'b0, 1'b0, busy_cycles, done_pulses);
        checkOutput("oai_busy_cycles", busy_cycles, 49);
        checkOutput("oai_done_pulses", done_pulses, 1);
        checkOutput("oai_pass", int'(pass_m), 1);
        checkOutput("oai_err", int'(err_m), 0);
        checkOutput("oai_ffvalid", int'(ffvalid_m), 0);
        checkOutput("oai_hold_vec", int'(vec_m), 15);

        // OAI22 cell checked as AOI22: differs at 3,5,6,9,10,12.
        applyStimulus(1'b0, 1'b1, 1'b0, busy_cycles, done_pulses);
        checkOutput("aoi_err", int'(err_m), 6);
        checkOutput("aoi_pass", int'(pass_m), 0);
        checkOutput("aoi_ffvalid", int'(ffvalid_m), 1);
        checkOutput("aoi_ffv", int'(ffv_m), 3);

        // Stuck-at-0 output: fails where OAI22 is 1 (0,1,2,3,4,8,12).
        fault = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, busy_cycles, done_pulses);
        checkOutput("stuck_err", int'(err_m), 7);
        checkOutput("stuck_ffv", int'(ffv_m), 0);
        checkOutput("stuck_ffvalid", int'(ffvalid_m), 1);
        checkOutput("stuck_pass", int'(pass_m), 0);

        // Reset during vector 5 of a stuck-at sweep (vectors 0..4 already failed).
        sel = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (16) @(negedge clk);
        checkOutput("mid_vec", int'(vec_m), 5);
        checkOutput("mid_err", int'(err_m), 5);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_busy", int'(busy_m), 0);
        checkOutput("rst_vec", int'(vec_m), 0);
        checkOutput("rst_err", int'(err_m), 0);
        checkOutput("rst_ffvalid", int'(ffvalid_m), 0);
        checkOutput("rst_done", int'(done_m), 0);
        done_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) rst = 1'b0;
            @(negedge clk);
            if (done_m || busy_m) done_pulses++;
        end
        checkOutput("rst_no_done", done_pulses, 0);

        fault = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, busy_cycles, done_pulses);
        checkOutput("post_rst_busy_cycles", busy_cycles, 49);
        checkOutput("post_rst_pass", int'(pass_m), 1);

        // start re-pulsed and mode flipped mid-sweep must be ignored.
        applyStimulus(1'b0, 1'b0, 1'b1, busy_cycles, done_pulses);
        checkOutput("disturb_busy_cycles", busy_cycles, 49);
        checkOutput("disturb_done_pulses", done_pulses, 1);
        checkOutput("disturb_err", int'(err_m), 0);
        checkOutput("disturb_pass", int'(pass_m), 1);

        // SETTLE_CYCLES = 1 instance.
        applyStimulus(1'b1, 1'b0, 1'b0, busy_cycles, done_pulses);
        checkOutput("s1_busy_cycles", busy_cycles, 33);
        checkOutput("s1_pass", int'(pass_m), 1);
        checkOutput("s1_err", int'(err_m), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, busy_cycles, done_pulses);
        checkOutput("s1_aoi_err", int'(err_m), 6);
        checkOutput("s1_aoi_ffv", int'(ffv_m), 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
